// File: rtl/lsu_ctrl.sv
// Load/store unit: turns an execute-stage memory op into a req/ack data-memory transaction.
// Optional macro LSU_BYTE_EN adds LB/LBU/SB byte-lane support; without it those codes are ignored.
module lsu_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [2:0]    mem_op,
  input  logic [31:0]   ex_addr,
  input  logic [31:0]   ex_wdata,
  input  logic [4:0]    ex_wreg,
  output logic          dm_req,
  output logic          dm_we,
  output logic [3:0]    dm_be,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic          dm_ack,
  input  logic [31:0]   dm_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [4:0]    wb_reg,
  output logic [31:0]   wb_data,
  output logic          adel,
  output logic          ades
);

  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q;
  logic [AW-1:2]  addr_q;
  logic [4:0]     wreg_q;
  logic [3:0]     be_q;
  logic           we_q;
  logic [31:0]    wdata_q;
  logic [31:0]    wb_data_q;
  logic           adel_q, ades_q;

  logic           op_ok, accept, misaligned, op_is_load_q;
  logic [3:0]     be_d;
  logic [31:0]    wdata_d;
  logic [31:0]    load_data;

`ifdef LSU_BYTE_EN
  logic [1:0]     lane_q;
  logic [7:0]     lane_byte;

  assign op_ok        = (mem_op == OP_LW) || (mem_op == OP_SW) || (mem_op == OP_LB) ||
                        (mem_op == OP_LBU) || (mem_op == OP_SB);
  assign op_is_load_q = (op_q == OP_LW) || (op_q == OP_LB) || (op_q == OP_LBU);
  assign be_d         = ((mem_op == OP_LW) || (mem_op == OP_SW)) ? 4'b1111
                                                                 : (4'b0001 << ex_addr[1:0]);
  assign wdata_d      = (mem_op == OP_SB) ? {4{ex_wdata[7:0]}} : ex_wdata;
  assign lane_byte    = 8'(dm_rdata >> {lane_q, 3'b000});

  always_comb begin
    load_data = 32'h0;
    case (op_q)
      OP_LW:   load_data = dm_rdata;
      OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_data = {24'h0, lane_byte};
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         lane_q <= 2'b00;
    else if (accept) lane_q <= ex_addr[1:0];
  end
`else
  assign op_ok        = (mem_op == OP_LW) || (mem_op == OP_SW);
  assign op_is_load_q = (op_q == OP_LW);
  assign be_d         = 4'b1111;
  assign wdata_d      = ex_wdata;
  assign load_data    = (op_q == OP_LW) ? dm_rdata : 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Word ops with a nonzero low address are flagged and dropped without touching memory.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && op_ok) begin
          accept     = 1'b1;
          misaligned = ((mem_op == OP_LW) || (mem_op == OP_SW)) && (ex_addr[1:0] != 2'b00);
          if (!misaligned) state_d = REQ;
        end
      end
      REQ:     if (dm_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 3'b000;
      addr_q    <= '0;
      wreg_q    <= 5'd0;
      be_q      <= 4'b0000;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      wb_data_q <= 32'h0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
    end else begin
      adel_q <= misaligned && (mem_op == OP_LW);
      ades_q <= misaligned && (mem_op == OP_SW);
      if (accept) begin
        op_q    <= mem_op;
        addr_q  <= ex_addr[AW-1:2];
        wreg_q  <= ex_wreg;
        be_q    <= be_d;
        we_q    <= (mem_op == OP_SW) || (mem_op == OP_SB);
        wdata_q <= wdata_d;
      end
      if ((state_q == REQ) && dm_ack) wb_data_q <= load_data;
    end
  end

  assign ex_ready = (state_q == IDLE);
  assign dm_req   = (state_q == REQ);
  assign dm_we    = we_q;
  assign dm_be    = be_q;
  assign dm_addr  = {addr_q, 2'b00};
  assign dm_wdata = wdata_q;
  assign wb_valid = (state_q == DONE);
  assign wb_we    = (state_q == DONE) && op_is_load_q;
  assign wb_reg   = wreg_q;
  assign wb_data  = wb_data_q;
  assign adel     = adel_q;
  assign ades     = ades_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scoreboard of expected write-backs plus per-cycle bus checks.
// Byte-lane tests run only when LSU_BYTE_EN is defined; otherwise byte codes must be ignored.
module tb_lsu_ctrl;

  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  mem_op;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_wreg;
  logic        dm_req, dm_we, dm_ack;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_we, adel, ades;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  typedef struct packed {
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
  } wb_t;

  wb_t expQ[$];
  int  checks = 0;
  int  failures = 0;
  int  wbSeen = 0;
  int  wbExpected = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .mem_op(mem_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_wreg(ex_wreg), .dm_req(dm_req), .dm_we(dm_we),
    .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .adel(adel), .ades(ades)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [2:0] op, input logic [1:0] lane,
                                          input logic [31:0] rdata);
    logic [7:0] b;
    b = rdata[8*lane +: 8];
    case (op)
      OP_LW:   return rdata;
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  // Every write-back pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      wbSeen++;
      if (expQ.size() == 0) begin
        checkOutput("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = expQ.pop_front();
        checkOutput("wb_we", {31'h0, wb_we}, {31'h0, e.we});
        checkOutput("wb_data", wb_data, e.data);
        if (e.we) checkOutput("wb_reg", {27'h0, wb_reg}, {27'h0, e.rg});
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctrl"},
                {17'h0, dm_req, dm_we, dm_be, wb_valid, wb_we, wb_reg, adel, ades, ex_ready},
                32'h0000_0001);
    checkOutput({tag, "_dm_addr"}, dm_addr, 32'h0);
    checkOutput({tag, "_dm_wdata"}, dm_wdata, 32'h0);
    checkOutput({tag, "_wb_data"}, wb_data, 32'h0);
  endtask

  // Called and returns at posedge+1; drives one op and plays the memory side with `waits` stall cycles.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] wreg, input int waits, input logic [31:0] rdata);
    int n;
    logic mis, isLoad, isStore;
    logic [3:0] be;
    logic [31:0] wd;
    wb_t e;
    n = 0;
    while (ex_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (ex_ready !== 1'b1) checkOutput("ready_timeout", 32'd0, 32'd1);
    ex_valid = 1'b1; mem_op = op; ex_addr = addr; ex_wdata = wdata; ex_wreg = wreg;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_op = 3'b000; ex_addr = $urandom; ex_wdata = $urandom;
    isLoad  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    isStore = (op == OP_SW) || (op == OP_SB);
    mis = ((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00);
    if (mis) begin
      @(negedge clk);
      checkOutput("adel", {31'h0, adel}, {31'h0, op == OP_LW});
      checkOutput("ades", {31'h0, ades}, {31'h0, op == OP_SW});
      checkOutput("mis_no_req", {31'h0, dm_req}, 32'd0);
      checkOutput("mis_ready", {31'h0, ex_ready}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("mis_pulse_end", {30'h0, adel, ades}, 32'd0);
      checkOutput("mis_no_req2", {31'h0, dm_req}, 32'd0);
      @(posedge clk); #1;
      return;
    end
    be = ((op == OP_LW) || (op == OP_SW)) ? 4'b1111 : (4'b0001 << addr[1:0]);
    wd = (op == OP_SB) ? {4{wdata[7:0]}} : wdata;
    e.we = isLoad; e.rg = wreg; e.data = isLoad ? expLoad(op, addr[1:0], rdata) : 32'h0;
    expQ.push_back(e);
    wbExpected++;
    for (int i = 0; i <= waits; i++) begin
      dm_ack = (i == waits);
      dm_rdata = (i == waits) ? rdata : $urandom;
      @(negedge clk);
      checkOutput("req", {31'h0, dm_req}, 32'd1);
      checkOutput("req_ready", {31'h0, ex_ready}, 32'd0);
      checkOutput("dm_addr", dm_addr, {addr[31:2], 2'b00});
      checkOutput("dm_be", {28'h0, dm_be}, {28'h0, be});
      checkOutput("dm_we", {31'h0, dm_we}, {31'h0, isStore});
      if (isStore) checkOutput("dm_wdata", dm_wdata, wd);
      @(posedge clk); #1;
    end
    dm_ack = 1'b0; dm_rdata = $urandom;
    @(negedge clk);
    checkOutput("done_valid", {31'h0, wb_valid}, 32'd1);
    checkOutput("done_ready", {31'h0, ex_ready}, 32'd0);
    checkOutput("done_no_req", {31'h0, dm_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("wb_pulse_end", {31'h0, wb_valid}, 32'd0);
    checkOutput("idle_ready", {31'h0, ex_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic ignoreOp(input logic [2:0] op);
    ex_valid = 1'b1; mem_op = op; ex_addr = 32'h0000_0040; ex_wdata = 32'hCAFE_F00D; ex_wreg = 5'd9;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_op = 3'b000;
    repeat (2) begin
      @(negedge clk);
      checkOutput($sformatf("ignore_%0d", op),
                  {28'h0, ex_ready, dm_req, adel, ades}, 32'h0000_0008);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_op = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
    ex_wreg = 5'd0; dm_ack = 1'b0; dm_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk); #1;

    applyStimulus(OP_LW, 32'h0000_0010, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);
    applyStimulus(OP_SW, 32'h0000_0020, 32'h1234_5678, 5'd6, 3, 32'h0);
    applyStimulus(OP_LW, 32'h0000_0013, 32'h0, 5'd7, 0, 32'h0);
    applyStimulus(OP_SW, 32'h0000_0022, 32'h5555_AAAA, 5'd8, 0, 32'h0);
    applyStimulus(OP_LW, 32'h8000_0FFC, 32'h0, 5'd0, 1, 32'h0BAD_F00D);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      applyStimulus((k % 2 == 0) ? OP_LW : OP_SW, a, $urandom, 5'($urandom_range(1, 31)),
                    $urandom_range(0, 2), $urandom);
    end

    ignoreOp(3'b000);
    ignoreOp(3'b110);
    ignoreOp(3'b111);
`ifdef LSU_BYTE_EN
    applyStimulus(OP_LB,  32'h0000_0103, 32'h0, 5'd10, 0, 32'h80FF_7F01);
    applyStimulus(OP_LBU, 32'h0000_0103, 32'h0, 5'd11, 1, 32'h80FF_7F01);
    applyStimulus(OP_LB,  32'h0000_0101, 32'h0, 5'd12, 0, 32'h80FF_7F01);
    applyStimulus(OP_LBU, 32'h0000_0100, 32'h0, 5'd13, 0, 32'h80FF_7F01);
    applyStimulus(OP_SB,  32'h0000_0202, 32'h0000_00AB, 5'd14, 2, 32'h0);
`else
    ignoreOp(OP_LB);
    ignoreOp(OP_LBU);
    ignoreOp(OP_SB);
`endif

    // Abort a pending read: reset mid-REQ, then a stale ack must not complete anything.
    ex_valid = 1'b1; mem_op = OP_LW; ex_addr = 32'h0000_0040; ex_wreg = 5'd3;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_op = 3'b000;
    @(negedge clk);
    checkOutput("abort_in_req", {31'h0, dm_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("abort");
    @(posedge clk); #1;
    dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("late_ack", {29'h0, wb_valid, dm_req, ex_ready}, 32'h0000_0001);
      @(posedge clk); #1;
    end

    applyStimulus(OP_LW, 32'h0000_0044, 32'h0, 5'd4, 0, 32'h7654_3210);

    checkOutput("sb_empty", expQ.size(), 32'd0);
    checkOutput("wb_count", wbSeen, wbExpected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
